counter_arbiter: RTL and testbench
==================================

Name: counter_arbiter

Overview:
- Round-robin arbiter/scheduler that shares one WIDTH-bit up-counter among NUM_REQ requesters.
- A granted requester owns the counter for up to MAX_HOLD increments. The counter advances one step per cycle while the owner keeps its request high.
- Sits between lab front-end requesters (buttons/FSMs) and the shared counter/display path. It drives the counter enable and exposes the count, owner and wrap events.

Parameters:
NUM_REQ, 4, number of requesters (2..8)
WIDTH, 2, counter width; count wraps modulo 2^WIDTH
MAX_HOLD, 4, max increments per grant before forced release (>=1)

Ports:
clk  input  1  rising-edge clock
reset  input  1  asynchronous, active-low reset (0 = reset)
req  input  NUM_REQ  level requests, one bit per requester
clear  input  1  synchronous counter clear
grant  output  NUM_REQ  one-hot current owner, registered
busy  output  1  1 when any grant is held
owner  output  clog2(NUM_REQ)  index of current owner, 0 when idle
counter_value  output  WIDTH  shared count
wrap  output  1  one-cycle pulse, registered, when count steps from 2^WIDTH-1 to 0

Behaviour:
- Reset: while reset=0, asynchronously force the following: grant=0, busy=0, owner=0, counter_value=0, wrap=0, hold_cnt=0, rr pointer=0, state=IDLE. Reset mid-burst aborts the grant immediately.
- States: IDLE, BUSY.
- IDLE, at each edge:
  - If req!=0, grant the first set bit searching from the pointer upward, wrapping around.
  - Enter BUSY with grant/owner registered and hold_cnt=0.
  - No increment occurs on the grant edge. Latency from req rise to grant is 1 edge.
- BUSY, owner g, at each edge:
  - req[g]=1 and hold_cnt<MAX_HOLD-1: counter+1, hold_cnt+1, stay.
  - req[g]=1 and hold_cnt==MAX_HOLD-1: counter+1 (final step), then release.
  - req[g]=0: no increment, release.
- Release, same edge:
  - Pointer becomes (g+1) mod NUM_REQ.
  - Re-arbitrate from the new pointer using the current req. The search includes g last, so a sole requester is re-granted.
  - If some req is set: new grant, hold_cnt=0, stay BUSY (no bubble).
  - If no req is set: grant=0, go to IDLE.
- Increment enable is (state==BUSY) & req[owner] at the edge.
- Count wraps 2^WIDTH-1 -> 0. wrap=1 for the cycle following that edge only.
- clear=1: counter_value <= 0 and wrap <= 0 at that edge.
  - clear overrides a same-edge increment, but the increment still counts toward hold_cnt.
  - clear does not affect arbitration.
- Requests from non-owners are ignored until release. A non-owner request does not preempt.
- req bits for non-existent requesters are not possible. Width is exactly NUM_REQ.
- busy = |grant. owner is the binary encoding of grant.

Optional Feature:
Macro: COUNTER_ARB_FIXED_PRIO_EN
- Defined:
  - The round-robin pointer is removed. Every arbitration picks the lowest-index set req bit (req[0] highest priority).
  - Hold and release rules are unchanged.
  - A continuously requesting req[0] wins every release.
- Undefined: round-robin as above.

Test Plan:
- Async reset: assert reset=0 mid-burst with count=2, no clk edge -> all outputs 0 immediately. Release reset, req=0 for 3 cycles -> outputs stay 0.
- Single requester, MAX_HOLD=4, req=4'b0001 held 10 edges:
  - grant=0001 after edge 1.
  - count 0,1,2,3,0,... increments on each subsequent edge, with no gap at the forced re-grant.
  - wrap pulses one cycle after 3->0.
- Round-robin, req=4'b0101 held:
  - grant sequence 0001 (4 increments) -> 0100 (4 increments) -> 0001.
  - counter wraps as expected. owner = 0,2,0.
- Early drop: owner 1 drops req[1] after 2 increments while req[3]=1 -> same edge grant=1000, count +0 on that edge, hold_cnt restarts.
- clear with increment: owner active, count=2, clear=1 one edge -> count=0 (not 3), wrap=0. hold_cnt still advances and release happens on schedule.
- With COUNTER_ARB_FIXED_PRIO_EN: req=4'b1001 held -> grant 0001 on every release, grant 1000 never asserted. Without the macro, the same stimulus alternates 0001/1000.

Source files
------------

// File: rtl/counter_arbiter_if.sv
// Request/grant/count bundle between the requester front-ends and counter_arbiter.
// Latency: none, wires only.
// Backpressure: none. Requests are level-held and the owner only advances while its bit stays high.
//
// Signals:
//   req           requester -> arbiter  one level request bit per requester
//   clear         requester -> arbiter  synchronous clear of the shared count
//   grant         arbiter -> requester  one-hot current owner (registered)
//   busy          arbiter -> requester  any grant held
//   owner         arbiter -> requester  binary index of owner, 0 when idle
//   counter_value arbiter -> requester  shared count
//   wrap          arbiter -> requester  one-cycle pulse after count wraps to 0
// Modports: master = requester side, slave = arbiter side.
interface counter_arbiter_if #(
    parameter int NUM_REQ = 4,
    parameter int WIDTH   = 2
);
    localparam int OW = $clog2(NUM_REQ);

    logic [NUM_REQ-1:0] req;
    logic               clear;
    logic [NUM_REQ-1:0] grant;
    logic               busy;
    logic [OW-1:0]      owner;
    logic [WIDTH-1:0]   counter_value;
    logic               wrap;

    modport master (
        output req,
        output clear,
        input  grant,
        input  busy,
        input  owner,
        input  counter_value,
        input  wrap
    );

    modport slave (
        input  req,
        input  clear,
        output grant,
        output busy,
        output owner,
        output counter_value,
        output wrap
    );
endinterface

// File: rtl/counter_arbiter.sv
// Arbitrates one shared WIDTH-bit up-counter among NUM_REQ requesters, MAX_HOLD increments per grant.
// Latency: grant 1 edge after req rises; count steps on each later edge while the owner holds req.
// Backpressure: the owner stalls the count by dropping req, which also releases the grant on that edge.
//
// Ports:
//   clk    rising-edge clock
//   reset  asynchronous active-low reset (0 = reset)
//   bus    counter_arbiter_if.slave: req/clear in; grant/busy/owner/counter_value/wrap out
//
// Build option COUNTER_ARB_FIXED_PRIO_EN: when defined, the round-robin pointer is removed
// and every arbitration picks the lowest-index requester (req[0] highest priority).
module counter_arbiter #(
    parameter int NUM_REQ  = 4,
    parameter int WIDTH    = 2,
    parameter int MAX_HOLD = 4
) (
    input  logic              clk,
    input  logic              reset,
    counter_arbiter_if.slave  bus
);
    localparam int OW = $clog2(NUM_REQ);
    localparam int HW = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } state_t;

    state_t             state_q;
    logic [NUM_REQ-1:0] grant_q;
    logic               busy_q;
    logic [OW-1:0]      owner_q;
    logic [WIDTH-1:0]   count_q;
    logic               wrap_q;
    logic [HW-1:0]      hold_q;
`ifndef COUNTER_ARB_FIXED_PRIO_EN
    logic [OW-1:0]      ptr_q;
    logic [OW-1:0]      rel_ptr;
`endif

    logic               inc_en;
    logic               last_step;
    logic               release_now;
    logic [OW-1:0]      base;
    logic [2*NUM_REQ-1:0] req_dbl;
    logic [NUM_REQ-1:0] req_rot;
    logic               pick_vld;
    logic [OW-1:0]      pick_off;
    logic [OW:0]        pick_sum;
    logic [OW-1:0]      pick_idx;

    // Arbitration and hold bookkeeping for the coming edge.
    always_comb begin
        inc_en      = (state_q == ST_BUSY) && bus.req[owner_q];
        last_step   = (hold_q == HW'(MAX_HOLD - 1));
        // Release on a dropped request, or on the final permitted increment.
        release_now = (state_q == ST_BUSY) && (!bus.req[owner_q] || last_step);

`ifdef COUNTER_ARB_FIXED_PRIO_EN
        base = '0;
`else
        rel_ptr = (owner_q == OW'(NUM_REQ - 1)) ? '0 : owner_q + 1'b1;
        // On release the search starts just past the old owner, so the old
        // owner is visited last and a sole requester is re-granted.
        base    = (state_q == ST_BUSY) ? rel_ptr : ptr_q;
`endif

        // Rotate so bit 0 of req_rot is the requester at the search base;
        // the lowest set bit of req_rot is then the winner's offset.
        req_dbl  = {bus.req, bus.req} >> base;
        req_rot  = req_dbl[NUM_REQ-1:0];
        pick_vld = 1'b0;
        pick_off = '0;
        for (int j = NUM_REQ - 1; j >= 0; j--) begin
            if (req_rot[j]) begin
                pick_vld = 1'b1;
                pick_off = OW'(j);
            end
        end
        pick_sum = {1'b0, base} + {1'b0, pick_off};
        if (pick_sum >= (OW+1)'(NUM_REQ)) begin
            pick_idx = OW'(pick_sum - (OW+1)'(NUM_REQ));
        end else begin
            pick_idx = pick_sum[OW-1:0];
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_IDLE;
            grant_q <= '0;
            busy_q  <= 1'b0;
            owner_q <= '0;
            count_q <= '0;
            wrap_q  <= 1'b0;
            hold_q  <= '0;
`ifndef COUNTER_ARB_FIXED_PRIO_EN
            ptr_q   <= '0;
`endif
        end else begin
            // Shared counter. clear wins over a same-edge increment; the
            // increment still counts against the owner's hold budget below.
            if (bus.clear) begin
                count_q <= '0;
                wrap_q  <= 1'b0;
            end else if (inc_en) begin
                count_q <= count_q + 1'b1;
                wrap_q  <= &count_q;
            end else begin
                wrap_q  <= 1'b0;
            end

            case (state_q)
                ST_IDLE: begin
                    if (pick_vld) begin
                        state_q <= ST_BUSY;
                        grant_q <= {{(NUM_REQ-1){1'b0}}, 1'b1} << pick_idx;
                        owner_q <= pick_idx;
                        busy_q  <= 1'b1;
                        hold_q  <= '0;
                    end
                end
                ST_BUSY: begin
                    if (release_now) begin
`ifndef COUNTER_ARB_FIXED_PRIO_EN
                        ptr_q <= rel_ptr;
`endif
                        hold_q <= '0;
                        if (pick_vld) begin
                            // Hand over on the same edge, no idle bubble.
                            grant_q <= {{(NUM_REQ-1){1'b0}}, 1'b1} << pick_idx;
                            owner_q <= pick_idx;
                            busy_q  <= 1'b1;
                        end else begin
                            state_q <= ST_IDLE;
                            grant_q <= '0;
                            owner_q <= '0;
                            busy_q  <= 1'b0;
                        end
                    end else begin
                        hold_q <= hold_q + 1'b1;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                    grant_q <= '0;
                    owner_q <= '0;
                    busy_q  <= 1'b0;
                    hold_q  <= '0;
                end
            endcase
        end
    end

    assign bus.grant         = grant_q;
    assign bus.busy          = busy_q;
    assign bus.owner         = owner_q;
    assign bus.counter_value = count_q;
    assign bus.wrap          = wrap_q;

endmodule

// File: tb/tb_counter_arbiter.sv
// Bench for counter_arbiter: directed literal checks plus randomized traffic
// compared every cycle against an integer-level model of the arbiter.
module tb_counter_arbiter;
    localparam int N    = 4;
    localparam int W    = 2;
    localparam int H    = 4;
    localparam int MAXC = (1 << W) - 1;

    logic clk   = 1'b0;
    logic reset = 1'b0;

    counter_arbiter_if #(.NUM_REQ(N), .WIDTH(W)) bus ();

    counter_arbiter #(.NUM_REQ(N), .WIDTH(W), .MAX_HOLD(H)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    // Model state: owner index or -1 when nobody holds the counter,
    // increments used in the current grant, search start, count, wrap.
    int m_owner = -1;
    int m_used  = 0;
    int m_ptr   = 0;
    int m_count = 0;
    int m_wrap  = 0;

    task automatic chk(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic bit bit_of(input int v, input int idx);
        return ((v >> idx) & 1) != 0;
    endfunction

    // First requester at or after 'start', wrapping; -1 if none.
    function automatic int search(input int r, input int start);
        for (int k = 0; k < N; k++) begin
            if (bit_of(r, (start + k) % N)) return (start + k) % N;
        end
        return -1;
    endfunction

    function automatic int arb_start(input int p);
`ifdef COUNTER_ARB_FIXED_PRIO_EN
        return 0 + (p * 0);
`else
        return p;
`endif
    endfunction

    task automatic model_reset();
        m_owner = -1;
        m_used  = 0;
        m_ptr   = 0;
        m_count = 0;
        m_wrap  = 0;
    endtask

    task automatic model_edge(input int r, input bit clr);
        bit inc;
        inc = (m_owner >= 0) && bit_of(r, m_owner);
        if (clr) begin
            m_count = 0;
            m_wrap  = 0;
        end else if (inc) begin
            m_wrap  = (m_count == MAXC) ? 1 : 0;
            m_count = (m_count + 1) % (MAXC + 1);
        end else begin
            m_wrap = 0;
        end

        if (m_owner < 0) begin
            m_owner = search(r, arb_start(m_ptr));
            m_used  = 0;
        end else begin
            if (inc) m_used++;
            if (!inc || m_used == H) begin
                m_ptr   = (m_owner + 1) % N;
                m_owner = search(r, arb_start(m_ptr));
                m_used  = 0;
            end
        end
    endtask

    always @(posedge clk) begin
        if (!reset) model_reset();
        else        model_edge(int'(bus.req), bus.clear);
    end

    // Compare process: outputs are registered, so the falling edge sees settled values.
    always @(negedge clk) begin
        if (reset) begin
            chk("grant", int'(bus.grant), (m_owner >= 0) ? (1 << m_owner) : 0);
            chk("busy",  int'(bus.busy),  (m_owner >= 0) ? 1 : 0);
            chk("owner", int'(bus.owner), (m_owner >= 0) ? m_owner : 0);
            chk("count", int'(bus.counter_value), m_count);
            chk("wrap",  int'(bus.wrap),  m_wrap);
        end
    end

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset     = 1'b0;
        bus.req   = '0;
        bus.clear = 1'b0;
        tick();
        tick();
        reset = 1'b1;
    endtask

    task automatic lit(input string name, input int g, input int o, input int c, input int w);
        chk({name, ".grant"}, int'(bus.grant), g);
        chk({name, ".owner"}, int'(bus.owner), o);
        chk({name, ".count"}, int'(bus.counter_value), c);
        chk({name, ".wrap"},  int'(bus.wrap), w);
    endtask

    int  own_b, own_d, own_e;
    bit  seen8;

    initial begin
        bus.req   = '0;
        bus.clear = 1'b0;
        reset     = 1'b0;
        tick();
        lit("rst", 0, 0, 0, 0);
        chk("rst.busy", int'(bus.busy), 0);
        reset = 1'b1;

        // Idle then a single requester: no increment on the grant edge,
        // no gap across the forced re-grant, wrap one cycle after 3->0.
        for (int i = 0; i < 3; i++) begin
            tick();
            lit("idle", 0, 0, 0, 0);
        end
        bus.req = 4'b0001;
        tick(); lit("single.e1", 1, 0, 0, 0);
        tick(); lit("single.e2", 1, 0, 1, 0);
        tick(); lit("single.e3", 1, 0, 2, 0);
        tick(); lit("single.e4", 1, 0, 3, 0);
        tick(); lit("single.e5", 1, 0, 0, 1);
        tick(); lit("single.e6", 1, 0, 1, 0);
        tick(); lit("single.e7", 1, 0, 2, 0);

        // Asynchronous reset mid-burst with count=2: outputs clear with no edge.
        #2 reset = 1'b0;
        #1;
        lit("async", 0, 0, 0, 0);
        chk("async.busy", int'(bus.busy), 0);
        tick();
        tick();
        bus.req = '0;
        reset   = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            lit("post_rst", 0, 0, 0, 0);
        end

        // Round-robin between requesters 0 and 2.
        do_reset();
        bus.req = 4'b0101;
        tick(); lit("rr.grant0", 1, 0, 0, 0);
        for (int i = 0; i < 4; i++) tick();
`ifdef COUNTER_ARB_FIXED_PRIO_EN
        own_b = 0;
`else
        own_b = 2;
`endif
        lit("rr.handover1", 1 << own_b, own_b, 0, 1);
        for (int i = 0; i < 4; i++) tick();
        lit("rr.handover2", 1, 0, 0, 1);

        // Early drop: owner 1 releases after 2 increments, requester 3 takes over same edge.
        do_reset();
        bus.req = 4'b1010;
        tick(); lit("drop.e1", 2, 1, 0, 0);
        tick(); tick();
        lit("drop.e3", 2, 1, 2, 0);
        bus.req = 4'b1000;
        tick(); lit("drop.e4", 8, 3, 2, 0);
        tick(); lit("drop.e5", 8, 3, 3, 0);

        // clear overrides the increment but still consumes hold budget.
        do_reset();
        bus.req = 4'b0011;
        tick(); tick(); tick();
        lit("clr.pre", 1, 0, 2, 0);
        bus.clear = 1'b1;
        tick(); lit("clr.edge", 1, 0, 0, 0);
        bus.clear = 1'b0;
`ifdef COUNTER_ARB_FIXED_PRIO_EN
        own_d = 0;
`else
        own_d = 1;
`endif
        tick(); lit("clr.release", 1 << own_d, own_d, 1, 0);

        // Requesters 0 and 3: alternate under round-robin, 0 always under fixed priority.
        do_reset();
        bus.req = 4'b1001;
        seen8   = 1'b0;
        for (int i = 1; i <= 13; i++) begin
            tick();
            if (bus.grant == 4'b1000) seen8 = 1'b1;
            if (i == 5) begin
`ifdef COUNTER_ARB_FIXED_PRIO_EN
                own_e = 0;
`else
                own_e = 3;
`endif
                chk("pair.owner5", int'(bus.owner), own_e);
            end
            if (i == 9) chk("pair.owner9", int'(bus.owner), 0);
        end
`ifdef COUNTER_ARB_FIXED_PRIO_EN
        chk("pair.seen1000", int'(seen8), 0);
`else
        chk("pair.seen1000", int'(seen8), 1);
`endif

        // Randomized traffic, checked every cycle by the compare process.
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 3) == 0) bus.req = 4'($urandom_range(0, 15));
            bus.clear = ($urandom_range(0, 15) == 0);
            if ($urandom_range(0, 299) == 0) begin
                reset = 1'b0;
                tick();
                reset = 1'b1;
            end
            tick();
        end

        bus.req   = '0;
        bus.clear = 1'b0;
        tick();
        tick();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
